// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: receive FSM states, framing constants and a byte-wide CRC-32 step.
package eth_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        PREAMBLE  = 2'd2,
        DATA      = 2'd3
    } rx_state_e;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
    localparam int         ETH_FCS_LEN       = 4;

    // Reflected IEEE 802.3 polynomial, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_mac_rx_if.sv
// GMII receive pins and frame-stream outputs of eth_mac_rx.
// With ETH_RX_STATS_EN defined the good/bad frame counters are carried as well.
interface eth_mac_rx_if;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_done;
    logic [15:0] rx_len;
    logic        rx_crc_ok;
    logic        rx_err;
`ifdef ETH_RX_STATS_EN
    logic [31:0] stat_good;
    logic [31:0] stat_bad;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  rx_data, rx_valid, rx_sof, rx_done, rx_len, rx_crc_ok, rx_err, stat_good, stat_bad
    );
    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output rx_data, rx_valid, rx_sof, rx_done, rx_len, rx_crc_ok, rx_err, stat_good, stat_bad
    );
`else
    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  rx_data, rx_valid, rx_sof, rx_done, rx_len, rx_crc_ok, rx_err
    );
    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output rx_data, rx_valid, rx_sof, rx_done, rx_len, rx_crc_ok, rx_err
    );
`endif
endinterface

// File: rtl/crc32_gen.sv
// Byte-serial Ethernet CRC-32 shared by the TX and RX MACs; crc_out is the complemented running value.
module crc32_gen
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        calc,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);
    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (calc) begin
            crc_d = crc32_byte(crc_q, data_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/eth_mac_rx.sv
// GMII receive MAC: strips preamble/SFD, streams the payload with the FCS held back, reports status per frame.
// Define ETH_RX_STATS_EN to add the stat_good/stat_bad frame counters.
module eth_mac_rx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst,
    eth_mac_rx_if.slave bus
);
    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] FCS_LEN = 16'(ETH_FCS_LEN);

    logic [7:0]      rxd_q;
    logic            dv_q;
    logic            er_q;
    logic            live_q;
    rx_state_e       state_q;
    rx_state_e       state_d;
    logic [3:0][7:0] dly_q;
    logic [3:0][7:0] dly_d;
    logic [15:0]     count_q;
    logic [15:0]     count_d;
    logic            er_flag_q;
    logic            er_flag_d;
    logic [7:0]      rx_data_q;
    logic [7:0]      rx_data_d;
    logic            rx_valid_q;
    logic            rx_valid_d;
    logic            rx_sof_q;
    logic            rx_sof_d;
    logic            rx_done_q;
    logic            rx_done_d;
    logic [15:0]     rx_len_q;
    logic [15:0]     rx_len_d;
    logic            rx_crc_ok_q;
    logic            rx_crc_ok_d;
    logic            rx_err_q;
    logic            rx_err_d;
    logic            shift;
    logic            emit;
    logic            sfd_seen;
    logic            eof;
    logic            have_fcs;
    logic [31:0]     crc_out;

    // live_q keeps WAIT_IDLE from trusting the reset value of dv_q before a real sample exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_q  <= '0;
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
            live_q <= 1'b0;
        end else begin
            rxd_q  <= bus.gmii_rxd;
            dv_q   <= bus.gmii_rx_dv;
            er_q   <= bus.gmii_rx_er;
            live_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (live_q && !dv_q) state_d = IDLE;
            IDLE: begin
                if (dv_q) state_d = (rxd_q == ETH_PREAMBLE_BYTE) ? PREAMBLE : WAIT_IDLE;
            end
            PREAMBLE: begin
                if (!dv_q)                           state_d = IDLE;
                else if (rxd_q == ETH_SFD_BYTE)      state_d = DATA;
                else if (rxd_q != ETH_PREAMBLE_BYTE) state_d = WAIT_IDLE;
            end
            DATA: if (!dv_q) state_d = IDLE;
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        sfd_seen = (state_q == PREAMBLE) && dv_q && (rxd_q == ETH_SFD_BYTE);
        shift    = (state_q == DATA) && dv_q;
        eof      = (state_q == DATA) && !dv_q;
        emit     = shift && (count_q >= FCS_LEN);
        have_fcs = count_q >= FCS_LEN;

        dly_d       = dly_q;
        count_d     = count_q;
        er_flag_d   = er_flag_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_sof_d    = 1'b0;
        rx_done_d   = 1'b0;
        rx_len_d    = '0;
        rx_crc_ok_d = 1'b0;
        rx_err_d    = 1'b0;

        if (sfd_seen) begin
            count_d   = '0;
            er_flag_d = 1'b0;
        end
        if (shift) begin
            dly_d = {dly_q[2:0], rxd_q};
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            if (er_q) er_flag_d = 1'b1;
        end
        // The oldest delay-line byte is payload once a newer byte proves it is not FCS.
        if (emit) begin
            rx_data_d  = dly_q[3];
            rx_valid_d = 1'b1;
            rx_sof_d   = (count_q == FCS_LEN);
        end
        if (eof) begin
            rx_done_d   = 1'b1;
            rx_len_d    = have_fcs ? (count_q - FCS_LEN) : 16'd0;
            rx_crc_ok_d = have_fcs && ({dly_q[0], dly_q[1], dly_q[2], dly_q[3]} == crc_out);
            rx_err_d    = er_flag_q || (count_q < MIN_LEN) || (count_q > MAX_LEN) || !rx_crc_ok_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q       <= '0;
            count_q     <= '0;
            er_flag_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_sof_q    <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_len_q    <= '0;
            rx_crc_ok_q <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            dly_q       <= dly_d;
            count_q     <= count_d;
            er_flag_q   <= er_flag_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_sof_q    <= rx_sof_d;
            rx_done_q   <= rx_done_d;
            rx_len_q    <= rx_len_d;
            rx_crc_ok_q <= rx_crc_ok_d;
            rx_err_q    <= rx_err_d;
        end
    end

    crc32_gen u_crc (
        .clk     (clk),
        .rst_n   (!rst),
        .init    (sfd_seen),
        .calc    (emit),
        .data_in (dly_q[3]),
        .crc_out (crc_out)
    );

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_sof    = rx_sof_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.rx_len    = rx_len_q;
    assign bus.rx_crc_ok = rx_crc_ok_q;
    assign bus.rx_err    = rx_err_q;

`ifdef ETH_RX_STATS_EN
    logic [31:0] stat_good_q;
    logic [31:0] stat_good_d;
    logic [31:0] stat_bad_q;
    logic [31:0] stat_bad_d;

    always_comb begin
        stat_good_d = stat_good_q;
        stat_bad_d  = stat_bad_q;
        if (rx_done_d) begin
            if (rx_err_d) stat_bad_d  = stat_bad_q + 32'd1;
            else          stat_good_d = stat_good_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_good_q <= '0;
            stat_bad_q  <= '0;
        end else begin
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
        end
    end

    assign bus.stat_good = stat_good_q;
    assign bus.stat_bad  = stat_bad_q;
`endif

endmodule
